multiword_add_seq: RTL and testbench

Sequencing controller for the shared N-bit ripple-carry adder slice. It computes a WORDS×N-bit addition or subtraction by feeding one N-bit word per cycle through a single adder instance, least-significant word first. Between words, it keeps the carry in a register. It sits between a requester with a start/ready/done handshake and the adder datapath, trading latency for area in wide arithmetic paths.

---
 rtl/multiword_add_seq_if.sv | 26 ++
 rtl/multiword_add_seq.sv | 126 ++++++++++++
 tb/tb_multiword_add_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_if.sv
// multiword_add_seq_if: requester-side handshake and operand/result bus for
// the word-serial wide adder controller.
//   master (requester): drives start/sub/cin/a/b, observes ready/busy/done/sum/cout
//   slave  (controller): the reverse
interface multiword_add_seq_if #(
    parameter int N     = 16,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (output start, sub, cin, a, b,
                    input  ready, busy, done, sum, cout);
    modport slave  (input  start, sub, cin, a, b,
                    output ready, busy, done, sum, cout);
endinterface

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: computes a WORDS*N-bit add/subtract by streaming one
// N-bit word per cycle (LS word first) through a single N-bit adder slice,
// carrying between words in a register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - slave side of multiword_add_seq_if (start/sub/cin/a/b in,
//          ready/busy/done/sum/cout out)

// One N-bit ripple-carry slice; the controller instantiates exactly one.
module mwa_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
endmodule

module multiword_add_seq #(
    parameter int N     = 16,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                    state, state_n;
    logic [IW-1:0]             idx;
    logic                      carry;
    logic [WORDS-1:0][N-1:0]   a_q, b_q, sum_q;
    logic                      cout_q;

    logic                      run, last;
    logic [N-1:0]              sl_a, sl_b, sl_s;
    logic                      sl_ci, sl_co;

    assign run  = (state == S_RUN);
    assign last = (idx == IW'(WORDS - 1));

    // Slice inputs are forced to zero outside RUN so the shared adder sees
    // no activity while idle.
    assign sl_a  = run ? a_q[idx] : '0;
    assign sl_b  = run ? b_q[idx] : '0;
    assign sl_ci = run & carry;

    mwa_slice #(.N(N)) u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (sl_ci),
        .s  (sl_s),
        .co (sl_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_n = S_RUN;
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: B is inverted on capture and the carry
    // seeded with 1, so the slice only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub | bus.cin;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        idx    <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[idx] <= sl_s;
                    carry      <= sl_co;
                    idx        <= idx + IW'(1);
                    // cout is published with the last word so it reads the
                    // final carry in DONE and holds until the next start.
                    if (last) cout_q <= sl_co;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed self-checking bench for multiword_add_seq
// (N=16, WORDS=4). Inputs are driven and outputs sampled on the falling edge.
module tb_multiword_add_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multiword_add_seq_if #(.N(16), .WORDS(4)) bus ();

    multiword_add_seq #(.N(16), .WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start one operation at the current falling edge, scramble the inputs
    // after acceptance, and check latency, result and return to IDLE.
    task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic tcin, input logic tsub,
                         input logic [63:0] es, input logic ec);
        int lat;
        bus.a = ta; bus.b = tb_v; bus.cin = tcin; bus.sub = tsub; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.cin = 1'($urandom); bus.sub = 1'($urandom);
        lat = 1;
        while (!bus.done && lat < 20) begin
            chk({tag, "_onehot"}, 64'(int'(bus.ready) + int'(bus.busy) + int'(bus.done)), 64'd1);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_sum"}, bus.sum, es);
        chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
        @(negedge clk);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk({tag, "_sum_hold"}, bus.sum, es);
    endtask

    initial begin
        int dcount;
        int lat;
        checks = 0;
        errors = 0;

        // Reset with random inputs, including a start request.
        rst = 1'b1;
        bus.start = 1'b1; bus.sub = 1'($urandom); bus.cin = 1'($urandom);
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_sum",   bus.sum,        64'd0);
        chk("rst_cout",  64'(bus.cout),  64'd0);

        do_op("ripple",   64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0);
        do_op("wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1);
        do_op("cin",      64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0);
        do_op("mixed",    64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
              64'h1234_5678_9ABC_DF00, 1'b0);
        do_op("sub_brw",  64'h0000_0001_0000_0000, 64'd1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1);
        do_op("sub_neg",  64'h0, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Handshake: start held high with new operands through RUN/DONE.
        bus.a = 64'd5; bus.b = 64'd3; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);                       // t+1
        bus.a = 64'h1234; bus.b = 64'h0234; bus.sub = 1'b1;
        dcount = 0;
        for (int c = 1; c <= 5; c++) begin
            dcount += int'(bus.done);
            if (c < 5) @(negedge clk);
        end                                   // now t+5
        chk("hs_done1",  64'(bus.done), 64'd1);
        chk("hs_sum1",   bus.sum, 64'd8);
        chk("hs_cout1",  64'(bus.cout), 64'd0);
        chk("hs_dcount", 64'(dcount), 64'd1);
        @(negedge clk);                       // t+6, start still high
        chk("hs_ready6", 64'(bus.ready), 64'd1);
        chk("hs_sum6",   bus.sum, 64'd8);
        @(negedge clk);                       // t+7
        bus.start = 1'b0;
        chk("hs_busy7", 64'(bus.busy), 64'd1);
        lat = 7;
        while (!bus.done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("hs_done_cycle", 64'(lat), 64'd11);
        chk("hs_sum2",  bus.sum, 64'h1000);
        chk("hs_cout2", 64'(bus.cout), 64'd1);
        @(negedge clk);

        // Reset during the second RUN cycle aborts without a done pulse.
        bus.a = 64'd5; bus.b = 64'd3; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);                       // t+1
        bus.start = 1'b0;
        @(negedge clk);                       // t+2, word 0 already written
        chk("mid_sum_w0", bus.sum, 64'd8);
        rst = 1'b1;
        @(negedge clk);                       // t+3
        rst = 1'b0;
        chk("mid_ready", 64'(bus.ready), 64'd1);
        chk("mid_busy",  64'(bus.busy),  64'd0);
        chk("mid_done",  64'(bus.done),  64'd0);
        chk("mid_sum",   bus.sum,        64'd0);
        chk("mid_cout",  64'(bus.cout),  64'd0);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            dcount += int'(bus.done);
        end
        chk("mid_no_done", 64'(dcount), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
